mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: NUM_REQ requesters share one full-width unsigned
// multiplier through a round-robin arbiter. The product lands in a single
// result register that is drained with a valid/ready handshake.
// Optional feature: define MULT_SHARE_ARBITER_STATS_EN to add the 16-bit
// op_count output, which counts result handshakes and wraps at 65535.
//
// state | meaning
// EMPTY | result register holds no product, res_valid low
// FULL  | result register holds a product waiting for res_ready
module mult_share_arbiter #(
  parameter int  a_BW    = 4,
  parameter int  b_BW    = 4,
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int P_W     = a_BW + b_BW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*a_BW-1:0] req_a,
  input  logic [NUM_REQ*b_BW-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [P_W-1:0]          res_product,
  output logic [ID_W-1:0]         res_id
`ifdef MULT_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]             op_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [P_W-1:0]  res_product_q, res_product_d;
  logic [ID_W-1:0] res_id_q, res_id_d;

  logic            issue_ok;
  logic            issue;
  logic            sel_found;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] cand;
  logic [a_BW-1:0] a_sel;
  logic [b_BW-1:0] b_sel;
  logic [P_W-1:0]  product;

  // A new operand pair may enter when the register is free or being drained.
  assign issue_ok = (state_q == EMPTY) | res_ready;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Operand mux in front of the single shared multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_id == ID_W'(i)) begin
        a_sel = req_a[i*a_BW +: a_BW];
        b_sel = req_b[i*b_BW +: b_BW];
      end
    end
  end

  assign product = P_W'(a_sel) * P_W'(b_sel);

  // One-hot accept strobe; held low during reset and under backpressure.
  always_comb begin
    req_ready = '0;
    if (!rst && issue_ok && sel_found) begin
      req_ready[sel_id] = 1'b1;
    end
  end

  assign issue = |(req_valid & req_ready);

  // Next state: issue loads the register, otherwise a drain empties it.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    res_product_d = res_product_q;
    res_id_d      = res_id_q;
    if (issue) begin
      state_d       = FULL;
      last_grant_d  = sel_id;
      res_product_d = product;
      res_id_d      = sel_id;
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  // State and result registers; last_grant resets so the first search starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      res_product_q <= '0;
      res_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      res_product_q <= res_product_d;
      res_id_q      <= res_id_d;
    end
  end

  assign res_valid   = (state_q == FULL);
  assign res_product = res_product_q;
  assign res_id      = res_id_q;

`ifdef MULT_SHARE_ARBITER_STATS_EN
  logic [15:0] op_count_q;

  // Count result handshakes; natural 16-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (res_valid && res_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter at default parameters (4 requesters,
// 4-bit operands). A transaction-level reference model predicts the accept
// strobe, result register contents and handshake count.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_product;
  logic [1:0]  res_id;
`ifdef MULT_SHARE_ARBITER_STATS_EN
  logic [15:0] op_count;
`endif

  mult_share_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
    .res_id      (res_id)
`ifdef MULT_SHARE_ARBITER_STATS_EN
    ,
    .op_count    (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // reference model state
  bit m_full;
  int m_prod;
  int m_id;
  int m_last;
  int m_ops;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_prod = 0;
    m_id   = 0;
    m_last = 3;
    m_ops  = 0;
  endtask

  // One clock cycle: drive at the falling edge, check the strobe, advance
  // the model across the rising edge, then check the result register.
  task automatic step(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                      input logic rr, output logic [3:0] rdy_obs);
    int g;
    int idx;
    logic [3:0] exp_rdy;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    #1;
    g = -1;
    if (!m_full || rr) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    rdy_obs = req_ready;
    check_eq("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (m_full && rr) m_ops++;
    if (g >= 0) begin
      m_full = 1'b1;
      m_prod = int'((a >> (4 * g)) & 16'hF) * int'((b >> (4 * g)) & 16'hF);
      m_id   = g;
      m_last = g;
    end else if (rr) begin
      m_full = 1'b0;
    end
    @(negedge clk);
    check_eq("res_valid", {31'd0, res_valid}, {31'd0, m_full});
    check_eq("res_product", {24'd0, res_product}, m_prod);
    check_eq("res_id", {30'd0, res_id}, m_id);
  endtask

  logic [3:0] r;
  logic [7:0] held_prod;
  logic [1:0] held_id;

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = 16'hFFFF;
    req_b     = 16'hFFFF;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'd0, res_valid}, 0);
    check_eq("rst_product", {24'd0, res_product}, 0);
    check_eq("rst_id", {30'd0, res_id}, 0);
    check_eq("rst_ready", {28'd0, req_ready}, 0);
    rst = 1'b0;

    // single request, product 3*5
    step(4'b0001, 16'h0003, 16'h0005, 1'b1, r);
    check_eq("first_grant", {28'd0, r}, 32'b0001);
    check_eq("first_product", {24'd0, res_product}, 15);
    check_eq("first_id", {30'd0, res_id}, 0);

    // park last_grant on requester 3, then full contention rotates 0..3 twice
    step(4'b1000, 16'($urandom), 16'($urandom), 1'b1, r);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 16'($urandom), 16'($urandom), 1'b1, r);
      check_eq("rr_grant", {28'd0, r}, 32'(1 << (i % 4)));
      check_eq("rr_id", {30'd0, res_id}, i % 4);
    end

    // backpressure: nothing accepted, result frozen, then drain+issue together
    held_prod = res_product;
    held_id   = res_id;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 16'($urandom), 16'($urandom), 1'b0, r);
      check_eq("bp_ready", {28'd0, r}, 0);
      check_eq("bp_prod_hold", {24'd0, res_product}, {24'd0, held_prod});
      check_eq("bp_id_hold", {30'd0, res_id}, {30'd0, held_id});
    end
    step(4'b1111, 16'($urandom), 16'($urandom), 1'b1, r);
    check_eq("bp_release_grant", {28'd0, r}, 32'(1 << ((int'(held_id) + 1) % 4)));
    check_eq("bp_release_valid", {31'd0, res_valid}, 1);

    // widest operands, no truncation
    step(4'b0100, 16'h0F00, 16'h0F00, 1'b1, r);
    check_eq("max_product", {24'd0, res_product}, 225);

    // asynchronous reset while FULL
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, res_valid}, 0);
    check_eq("async_rst_prod", {24'd0, res_product}, 0);
    check_eq("async_rst_ready", {28'd0, req_ready}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b1010, 16'($urandom), 16'($urandom), 1'b1, r);
    check_eq("post_rst_grant", {28'd0, r}, 32'b0010);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0), r);
    end

`ifdef MULT_SHARE_ARBITER_STATS_EN
    check_eq("op_count", {16'd0, op_count}, m_ops % 65536);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
